// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches and holds one fetched word for IF/ID.
// Latency: a zero-wait response lands in the output buffer one cycle after the request.
// Backpressure: stall holds the buffer and blocks new requests while it is full; a request stays up until ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        if_id_sel,
  output logic        flush
);

  // FETCH: nothing outstanding; WAIT: outstanding, keep result; DROP: outstanding, discard result
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        vld_q, vld_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;

  logic        in_fetch;
  logic        consume;
  logic        buf_free;
  logic        req_raw;
  logic [31:0] tgt_aligned;

  // Request generation and pass-through control outputs; reset forces everything quiet
  always_comb begin
    in_fetch    = (state_q == S_FETCH);
    consume     = vld_q & ~stall;
    buf_free    = ~vld_q | consume;
    tgt_aligned = branch_target & ~32'd3;
    // An outstanding request is never withdrawn, so WAIT/DROP always request
    req_raw     = in_fetch ? (buf_free & ~branch_taken) : 1'b1;
    imem_req    = rst & req_raw;
    imem_addr   = rst ? (in_fetch ? pc_q : req_addr_q) : 32'h0;
    if_id_sel   = rst & ~stall;
    flush       = rst & branch_taken;
    // Buffer registers are cleared on invalidation, so these read 0 when empty
    pc_out      = pc4_q;
    instr_out   = instr_q;
  end

  // Next-state: branch wins over everything, then response handling per state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    vld_d      = vld_q;
    pc4_d      = pc4_q;
    instr_d    = instr_q;

    if (consume) begin
      vld_d   = 1'b0;
      pc4_d   = 32'h0;
      instr_d = 32'h0;
    end

    if (branch_taken) begin
      vld_d   = 1'b0;
      pc4_d   = 32'h0;
      instr_d = 32'h0;
      pc_d    = tgt_aligned;
      if (in_fetch) begin
        state_d = S_FETCH;
      end else begin
        // A response arriving in the same cycle is simply dropped
        state_d = imem_ready ? S_FETCH : S_DROP;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (req_raw) begin
            req_addr_d = pc_q;
            if (imem_ready) begin
              vld_d   = 1'b1;
              pc4_d   = pc_q + 32'd4;
              instr_d = imem_rdata;
              pc_d    = pc_q + 32'd4;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Buffer is always empty here: WAIT is only entered with a free buffer
          if (imem_ready) begin
            vld_d   = 1'b1;
            pc4_d   = req_addr_q + 32'd4;
            instr_d = imem_rdata;
            pc_d    = req_addr_q + 32'd4;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'h0;
      vld_q      <= 1'b0;
      pc4_q      <= 32'h0;
      instr_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      vld_q      <= vld_d;
      pc4_q      <= pc4_d;
      instr_q    <= instr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus, abstract reference model, per-cycle comparison.
// Latency: inputs change 1ns after each rising edge, outputs are sampled on the falling edge.
// Backpressure: stall and imem_ready are driven directly from the directed vectors.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        if_id_sel;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch pc, one outstanding request (maybe marked for discard), output buffer
  logic [31:0] m_pc        = RESET_PC;
  logic        m_pend      = 1'b0;
  logic [31:0] m_pend_addr = 32'h0;
  logic        m_kill      = 1'b0;
  logic        m_bv        = 1'b0;
  logic [31:0] m_bpc4      = 32'h0;
  logic [31:0] m_binstr    = 32'h0;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .if_id_sel    (if_id_sel),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // A request is up if one is outstanding, or if the buffer can take a word and no branch is redirecting
  function automatic logic m_req();
    return rst && (m_pend || ((!m_bv || !stall) && !branch_taken));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_pend ? m_pend_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model at each rising edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc        <= RESET_PC;
      m_pend      <= 1'b0;
      m_pend_addr <= 32'h0;
      m_kill      <= 1'b0;
      m_bv        <= 1'b0;
      m_bpc4      <= 32'h0;
      m_binstr    <= 32'h0;
    end else if (branch_taken) begin
      m_bv <= 1'b0;
      m_pc <= branch_target & ~32'd3;
      if (m_pend && !imem_ready) begin
        m_kill <= 1'b1;
      end else begin
        m_pend <= 1'b0;
        m_kill <= 1'b0;
      end
    end else begin
      if (m_bv && !stall) m_bv <= 1'b0;
      if (m_req() && imem_ready) begin
        if (!m_kill) begin
          m_bv     <= 1'b1;
          m_bpc4   <= m_addr() + 32'd4;
          m_binstr <= imem_rdata;
          m_pc     <= m_addr() + 32'd4;
        end
        m_pend <= 1'b0;
        m_kill <= 1'b0;
      end else if (m_req()) begin
        m_pend      <= 1'b1;
        m_pend_addr <= m_addr();
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("pc_out", pc_out, m_bv ? m_bpc4 : 32'h0);
    chk("instr_out", instr_out, m_bv ? m_binstr : 32'h0);
    chk("if_id_sel", {31'b0, if_id_sel}, {31'b0, rst && !stall});
    chk("flush", {31'b0, flush}, {31'b0, rst && branch_taken});
  end

  // One cycle: drive inputs just after the rising edge, return at the falling edge
  task automatic step(input logic r_n, input logic s, input logic b,
                      input logic [31:0] t, input logic rdy);
    @(posedge clk);
    #1;
    rst           = r_n;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    imem_ready    = rdy;
    #1;
    imem_rdata    = instr_of(m_addr());
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    #2 rst = 1'b0;

    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 1);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);

    // Zero-wait streaming from RESET_PC
    step(1, 0, 0, 32'h0, 1);
    chk("c1_req", {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    chk("c2_addr", imem_addr, 32'h4);
    chk("c2_pc_out", pc_out, 32'h4);
    chk("c2_instr", instr_out, 32'hC0DE_0000);
    step(1, 0, 0, 32'h0, 1);
    chk("c3_addr", imem_addr, 32'h8);
    chk("c3_pc_out", pc_out, 32'h8);
    chk("c3_instr", instr_out, 32'hC0DE_0004);
    step(1, 0, 0, 32'h0, 1);
    chk("c4_pc_out", pc_out, 32'hC);
    chk("c4_instr", instr_out, 32'hC0DE_0008);

    // Three wait cycles at 0x10
    step(1, 0, 0, 32'h0, 0);
    chk("w_addr0", imem_addr, 32'h10);
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    chk("w_addr2", imem_addr, 32'h10);
    chk("w_req2", {31'b0, imem_req}, 32'h1);
    chk("w_instr", instr_out, 32'h0);
    chk("w_sel", {31'b0, if_id_sel}, 32'h1);
    step(1, 0, 0, 32'h0, 1);
    chk("w_addr3", imem_addr, 32'h10);
    step(1, 0, 0, 32'h0, 1);
    chk("w_done_pc", pc_out, 32'h14);
    chk("w_done_instr", instr_out, 32'hC0DE_0010);

    // Stall two cycles with pc4 = 0x24 buffered
    repeat (3) step(1, 0, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 1);
    chk("st_pc_out", pc_out, 32'h24);
    chk("st_instr", instr_out, 32'hC0DE_0020);
    chk("st_req", {31'b0, imem_req}, 32'h0);
    chk("st_sel", {31'b0, if_id_sel}, 32'h0);
    step(1, 1, 0, 32'h0, 1);
    chk("st2_pc_out", pc_out, 32'h24);
    step(1, 0, 0, 32'h0, 1);
    chk("st_resume_addr", imem_addr, 32'h24);

    // Branch to 0x103 while waiting at 0x40
    repeat (6) step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);
    chk("br_wait_addr", imem_addr, 32'h40);
    step(1, 0, 1, 32'h103, 0);
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_hold_addr", imem_addr, 32'h40);
    step(1, 0, 0, 32'h0, 0);
    chk("drop_addr", imem_addr, 32'h40);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("br_tgt_addr", imem_addr, 32'h100);
    chk("br_drop_pc", pc_out, 32'h0);
    chk("br_drop_instr", instr_out, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    chk("br_first_pc", pc_out, 32'h104);
    chk("br_first_instr", instr_out, 32'hC0DE_0100);

    // Branch together with stall
    step(1, 1, 1, 32'h200, 1);
    chk("bs_flush", {31'b0, flush}, 32'h1);
    chk("bs_req", {31'b0, imem_req}, 32'h0);
    step(1, 0, 0, 32'h0, 0);
    chk("bs_addr", imem_addr, 32'h200);
    chk("bs_pc_out", pc_out, 32'h0);

    // Branch with same-cycle response, then pc wrap at the top of memory
    step(1, 0, 1, 32'hFFFF_FFFF, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0, 1);
    chk("wrap_pc_out", pc_out, 32'h0);
    chk("wrap_instr", instr_out, 32'h3F21_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset asserted mid-wait, late response during reset, then restart
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("mr_req", {31'b0, imem_req}, 32'h0);
    chk("mr_pc_out", pc_out, 32'h0);
    chk("mr_instr", instr_out, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);
    chk("mr_restart_req", {31'b0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr, RESET_PC);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("mr_pc_out2", pc_out, 32'h4);
    chk("mr_instr2", instr_out, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
